pipe_stage_skid_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (EX/MEM, MEM/WB and similar boundaries) with valid/ready flow control.

---
 rtl/pipe_stage_skid_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_skid_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: two-entry (main + skid) inter-stage pipeline register with valid/ready, flush and flush-discard counter
module pipe_stage_skid_reg #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 4,
    parameter int DST_W       = 5,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [DST_W-1:0]  out_dst,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam int EW = CTRL_W + 2 * DATA_W + DST_W;
    localparam int SW = CNT_W + 2;
    localparam logic [EW-1:0] BUBBLE_MASK = (ZERO_BUBBLE != 0) ?
        {{CTRL_W{1'b0}}, {(2 * DATA_W){1'b1}}, {DST_W{1'b0}}} : {EW{1'b1}};
    state_t            state_q, state_d;
    logic [EW-1:0]     main_q, main_d, skid_q, skid_d, in_e;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     sum;
    logic [1:0]        held;
    logic              acc, drn;
    assign in_e = {in_ctrl, in_alu, in_wdata, in_dst};
    assign acc  = in_valid & in_ready;
    assign drn  = out_valid & out_ready;
    // state, entry and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state: flush empties the stage and drops the input; a bubble clears ctrl/dst so it acts as a NOP
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q & BUBBLE_MASK;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    state_d = ONE;
                    main_d  = in_e;
                end
                ONE: if (acc && drn) begin
                    main_d = in_e;
                end else if (acc) begin
                    state_d = TWO;
                    skid_d  = in_e;
                end else if (drn) begin
                    state_d = EMPTY;
                    main_d  = main_q & BUBBLE_MASK;
                end
                TWO: if (drn) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        held  = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
        sum   = {2'b00, cnt_q} + SW'(held) + SW'(acc) - SW'(drn);
        cnt_d = flush ? ((|sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0]) : cnt_q;
    end
    // outputs decoded from registers only, so out_ready never reaches in_ready combinationally
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
        {out_ctrl, out_alu, out_wdata, out_dst} = main_q;
        flush_cnt = cnt_q;
    end
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed vectors with a queue scoreboard checking the skid pipeline stage
module tb_pipe_stage_skid_reg;
    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] w;
        logic [4:0]  d;
    } ent_t;
    logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [3:0]  in_ctrl = 0, out_ctrl;
    logic [31:0] in_alu = 0, in_wdata = 0, out_alu, out_wdata;
    logic [4:0]  in_dst = 0, out_dst;
    logic [7:0]  flush_cnt;
    ent_t        q[$];
    ent_t        e;
    int          n_vec = 0, n_err = 0;
    bit          armed = 0;

    pipe_stage_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_wdata(out_wdata), .out_dst(out_dst),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w, input logic [4:0] d);
        in_valid = 1;
        in_ctrl  = c;
        in_alu   = a;
        in_wdata = w;
        in_dst   = d;
    endtask

    // one cycle; expected entry is queued when the handshake completes
    task automatic step();
        @(negedge clk);
        if (!reset && !flush && in_valid && in_ready)
            q.push_back('{in_ctrl, in_alu, in_wdata, in_dst});
        @(posedge clk);
        #1;
    endtask

    // monitor: pops on every downstream transfer, clears on flush/reset, checks bubbles are NOPs
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else if (armed) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", 80'(out_alu), 80'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("sb_entry", 80'({out_ctrl, out_alu, out_wdata, out_dst}), 80'(e));
                end
            end
            if (!out_valid) chk("bubble_ctrl_dst", 80'({out_ctrl, out_dst}), 80'(0));
            if (flush) q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        reset = 0;
        armed = 1;
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_in_ready", 80'(in_ready), 80'(1));
        chk("rst_flush_cnt", 80'(flush_cnt), 80'(0));
        chk("rst_out_alu", 80'(out_alu), 80'(0));
        // 1: single entry, one-cycle latency
        out_ready = 1;
        drive(4'h1, 32'h1234, 32'h5678, 5'd3);
        step();
        in_valid = 0;
        chk("t1_out_valid", 80'(out_valid), 80'(1));
        chk("t1_out_alu", 80'(out_alu), 80'h1234);
        chk("t1_in_ready", 80'(in_ready), 80'(1));
        step();
        chk("t1_drained", 80'(out_valid), 80'(0));
        // 2: fill to TWO, then drain in order
        out_ready = 0;
        drive(4'h2, 32'hA, 32'hA0, 5'd4);
        step();
        drive(4'h3, 32'hB, 32'hB0, 5'd5);
        step();
        in_valid = 0;
        chk("t2_in_ready_two", 80'(in_ready), 80'(0));
        chk("t2_head_A", 80'(out_alu), 80'hA);
        out_ready = 1;
        step();
        chk("t2_then_B", 80'(out_alu), 80'hB);
        chk("t2_in_ready_one", 80'(in_ready), 80'(1));
        step();
        chk("t2_empty", 80'(out_valid), 80'(0));
        // 3: flush in TWO with a valid input and no drain
        out_ready = 0;
        drive(4'h4, 32'hC, 32'hC0, 5'd6);
        step();
        drive(4'h5, 32'hD, 32'hD0, 5'd7);
        step();
        drive(4'h6, 32'hE, 32'hE0, 5'd8);
        flush = 1;
        step();
        flush = 0;
        in_valid = 0;
        chk("t3_out_valid", 80'(out_valid), 80'(0));
        chk("t3_out_ctrl", 80'(out_ctrl), 80'(0));
        chk("t3_out_dst", 80'(out_dst), 80'(0));
        chk("t3_flush_cnt", 80'(flush_cnt), 80'(2));
        // 4: streaming acc&drn, one per cycle
        out_ready = 1;
        drive(4'b1001, 32'h11, 32'h1, 5'd9);
        chk("t4_rdy0", 80'(in_ready), 80'(1));
        step();
        chk("t4_ctrl0", 80'(out_ctrl), 80'b1001);
        drive(4'b0101, 32'h22, 32'h2, 5'd10);
        chk("t4_rdy1", 80'(in_ready), 80'(1));
        step();
        chk("t4_ctrl1", 80'(out_ctrl), 80'b0101);
        drive(4'b0011, 32'h33, 32'h3, 5'd11);
        chk("t4_rdy2", 80'(in_ready), 80'(1));
        step();
        chk("t4_ctrl2", 80'(out_ctrl), 80'b0011);
        in_valid = 0;
        step();
        chk("t4_empty", 80'(out_valid), 80'(0));
        // flush in ONE with same-cycle drain and valid input: 1 - 1 + 1 = +1
        out_ready = 0;
        drive(4'h7, 32'hF, 32'hF0, 5'd12);
        step();
        drive(4'h8, 32'h10, 32'h100, 5'd13);
        out_ready = 1;
        flush = 1;
        step();
        chk("flush_drn_cnt", 80'(flush_cnt), 80'(3));
        // 5: saturation, starting from 3
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) chk("t5_first", 80'(flush_cnt), 80'(4));
            if (i == 250) chk("t5_fe", 80'(flush_cnt), 80'hFE);
            if (i == 251) chk("t5_ff", 80'(flush_cnt), 80'hFF);
        end
        chk("t5_sat", 80'(flush_cnt), 80'hFF);
        flush = 0;
        in_valid = 0;
        step();
        // 6: reset mid-stream in TWO
        out_ready = 0;
        drive(4'h9, 32'h44, 32'h4, 5'd14);
        step();
        drive(4'hA, 32'h55, 32'h5, 5'd15);
        step();
        drive(4'hB, 32'h66, 32'h6, 5'd16);
        reset = 1;
        step();
        reset = 0;
        in_valid = 0;
        chk("t6_outs", 80'({out_valid, out_ctrl, out_alu, out_wdata, out_dst}), 80'(0));
        chk("t6_in_ready", 80'(in_ready), 80'(1));
        chk("t6_flush_cnt", 80'(flush_cnt), 80'(0));
        out_ready = 1;
        drive(4'hC, 32'h77, 32'h7, 5'd17);
        step();
        in_valid = 0;
        chk("t6_next_alu", 80'(out_alu), 80'h77);
        step();
        step();
        chk("sb_leftover", 80'(q.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
